coin_beam_sensor: RTL



---
 rtl/coin_beam_sensor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/coin_beam_sensor.sv
// rtl/coin_beam_sensor.sv - coin beam-break synchronizer, debouncer and pending-coin counters
// Debounce qualification is built only when COIN_BEAM_DEBOUNCE_EN is defined.
module coin_beam_sensor #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 30000,
  parameter int CNT_W           = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         beam_in,
  input  logic                      ack_wr,
  input  logic [NUM_CH-1:0]         ack_mask,
  output logic [NUM_CH-1:0]         pending,
  output logic [NUM_CH*CNT_W-1:0]   count,
  output logic [NUM_CH-1:0]         overflow,
  output logic [NUM_CH-1:0]         led
);

  localparam logic [1:0] ST_CLEAR      = 2'd0;
  localparam logic [1:0] ST_BREAK_QUAL = 2'd1;
  localparam logic [1:0] ST_BROKEN     = 2'd2;
  localparam logic [1:0] ST_CLEAR_QUAL = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_debounce
    $error("coin_beam_sensor: DEBOUNCE_CYCLES out of range");
  end

  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [1:0]        state_q [NUM_CH];
  logic [1:0]        state_d [NUM_CH];
  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];
  logic [NUM_CH-1:0] overflow_q, overflow_d;
  logic [NUM_CH-1:0] event_v;
  logic [NUM_CH-1:0] ack_hit;

`ifdef COIN_BEAM_DEBOUNCE_EN
  localparam int              DBC_W    = 20;
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  logic [DBC_W-1:0] dbc_q [NUM_CH];
  logic [DBC_W-1:0] dbc_d [NUM_CH];
`endif

  assign sync1_d = beam_in;
  assign sync2_d = sync1_q;
  assign ack_hit = {NUM_CH{ack_wr}} & ack_mask;

  // Debounce FSM: a qualified transition into BROKEN is the only source of coin events.
  always_comb begin
    event_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
`ifdef COIN_BEAM_DEBOUNCE_EN
      dbc_d[i] = dbc_q[i];
      case (state_q[i])
        ST_CLEAR: begin
          if (!sync2_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[i] = ST_BROKEN;
              event_v[i] = 1'b1;
            end else begin
              state_d[i] = ST_BREAK_QUAL;
              dbc_d[i]   = DBC_W'(1);
            end
          end
        end
        ST_BREAK_QUAL: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_CLEAR;
            dbc_d[i]   = '0;
          end else if (dbc_q[i] == DBC_LAST) begin
            state_d[i] = ST_BROKEN;
            event_v[i] = 1'b1;
            dbc_d[i]   = '0;
          end else begin
            dbc_d[i] = dbc_q[i] + DBC_W'(1);
          end
        end
        ST_BROKEN: begin
          if (sync2_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[i] = ST_CLEAR;
            end else begin
              state_d[i] = ST_CLEAR_QUAL;
              dbc_d[i]   = DBC_W'(1);
            end
          end
        end
        default: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_BROKEN;
            dbc_d[i]   = '0;
          end else if (dbc_q[i] == DBC_LAST) begin
            state_d[i] = ST_CLEAR;
            dbc_d[i]   = '0;
          end else begin
            dbc_d[i] = dbc_q[i] + DBC_W'(1);
          end
        end
      endcase
`else
      case (state_q[i])
        ST_CLEAR: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_BROKEN;
            event_v[i] = 1'b1;
          end
        end
        ST_BROKEN: begin
          if (sync2_q[i]) state_d[i] = ST_CLEAR;
        end
        ST_BREAK_QUAL: state_d[i] = ST_CLEAR;
        default:       state_d[i] = ST_BROKEN;
      endcase
`endif
    end
  end

  // Event and ack on the same edge cancel, which also covers event+ack at zero and at max.
  always_comb begin
    overflow_d = overflow_q;
    for (int i = 0; i < NUM_CH; i++) begin
      count_d[i] = count_q[i];
      if (event_v[i] && !ack_hit[i]) begin
        if (count_q[i] == CNT_MAX) overflow_d[i] = 1'b1;
        else                       count_d[i]    = count_q[i] + CNT_W'(1);
      end else if (ack_hit[i] && !event_v[i] && count_q[i] != '0) begin
        count_d[i] = count_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      overflow_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_CLEAR;
        count_q[i] <= '0;
`ifdef COIN_BEAM_DEBOUNCE_EN
        dbc_q[i]   <= '0;
`endif
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
`ifdef COIN_BEAM_DEBOUNCE_EN
        dbc_q[i]   <= dbc_d[i];
`endif
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count[i*CNT_W +: CNT_W] = count_q[i];
      pending[i]              = (count_q[i] != '0);
      led[i]                  = (state_q[i] == ST_BROKEN) || (state_q[i] == ST_CLEAR_QUAL);
    end
  end

  assign overflow = overflow_q;

endmodule
